// File: rtl/fifo_sram_ctrl_pkg.sv
// Shared types and timing defaults for the BRAM FIFO macro controller.
package fifo_sram_ctrl_pkg;

  typedef enum logic [1:0] {
    S_PRE,
    S_RST,
    S_POST,
    S_RUN
  } state_t;

  localparam int DEF_PRE_CYCLES  = 2;
  localparam int DEF_RST_CYCLES  = 5;
  localparam int DEF_POST_CYCLES = 2;

  // Width of the sequencing counter; every phase length must fit below 2**SEQ_W.
  localparam int SEQ_W = 8;

  function automatic logic [SEQ_W-1:0] last_cycle(input int cycles);
    return SEQ_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/fifo_sram_ctrl_skid.sv
// Two-entry prefetch buffer turning the macro's 1-cycle read latency into
// first-word-fall-through output.
module fifo_sram_ctrl_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  rd_issue,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  pop,
  output logic [1:0]            buf_cnt,
  output logic                  inflight,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;

  assign valid = (buf_cnt != 2'd0);
  assign data  = ent0;

  // ent0 is always the oldest word; a returning read lands behind whatever survives the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
      ent0     <= '0;
      ent1     <= '0;
    end else if (clear) begin
      buf_cnt  <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      case ({pop, inflight})
        2'b11: begin
          if (buf_cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= rd_data;
          end else begin
            ent0 <= rd_data;
          end
        end
        2'b10: begin
          ent0    <= ent1;
          buf_cnt <= buf_cnt - 2'd1;
        end
        2'b01: begin
          if (buf_cnt == 2'd0) ent0 <= rd_data;
          else                 ent1 <= rd_data;
          buf_cnt <= buf_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_sram_ctrl.sv
// Sequences the FIFO macro reset/flush, gates its WREN/RDEN and presents
// valid/ready push and pop interfaces with an exact occupancy count.
module fifo_sram_ctrl
  import fifo_sram_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 512,
  parameter int PRE_CYCLES  = DEF_PRE_CYCLES,
  parameter int RST_CYCLES  = DEF_RST_CYCLES,
  parameter int POST_CYCLES = DEF_POST_CYCLES,
  parameter int CNT_W       = $clog2(DEPTH + 3)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic                  mac_rst_o,
  output logic                  mac_wren_o,
  output logic [DATA_WIDTH-1:0] mac_di_o,
  output logic                  mac_rden_o,
  input  logic [DATA_WIDTH-1:0] mac_do_i,
  input  logic                  mac_empty_i,
  input  logic                  mac_full_i,
  input  logic                  mac_rderr_i,
  input  logic                  mac_wrerr_i
);

  state_t           state;
  logic [SEQ_W-1:0] seq_cnt;
  logic             run;
  logic             push;
  logic             out_fire;
  logic             buf_valid;
  logic [1:0]       buf_cnt;
  logic             inflight;
  logic [1:0]       occ;

  assign run        = (state == S_RUN);
  assign busy_o     = ~run;
  assign mac_rst_o  = (state == S_RST);

  assign in_ready_o = run & ~mac_full_i & ~flush_i;
  assign push       = in_valid_i & in_ready_o;
  assign mac_wren_o = push;
  assign mac_di_o   = run ? in_data_i : '0;

  assign out_valid_o = run & buf_valid;
  assign out_fire    = out_valid_o & out_ready_i;

  // A read may be issued into a full pipeline only when the head leaves this same cycle.
  assign occ        = buf_cnt + {1'b0, inflight};
  assign mac_rden_o = run & ~flush_i & ~mac_empty_i &
                      ((occ < 2'd2) | ((occ == 2'd2) & out_fire));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_RST;
      seq_cnt <= '0;
      err_o   <= 1'b0;
    end else begin
      case (state)
        S_PRE: begin
          if (seq_cnt == last_cycle(PRE_CYCLES)) begin
            state   <= S_RST;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end
        S_RST: begin
          if (seq_cnt == last_cycle(RST_CYCLES)) begin
            state   <= S_POST;
            seq_cnt <= '0;
            err_o   <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end
        S_POST: begin
          if (seq_cnt == last_cycle(POST_CYCLES)) begin
            state   <= S_RUN;
            seq_cnt <= '0;
          end else begin
            seq_cnt <= seq_cnt + SEQ_W'(1);
          end
        end
        S_RUN: begin
          if (flush_i) begin
            state   <= S_PRE;
            seq_cnt <= '0;
          end
          if (mac_rderr_i | mac_wrerr_i) err_o <= 1'b1;
        end
        default: begin
          state   <= S_RST;
          seq_cnt <= '0;
        end
      endcase
    end
  end

  // Occupancy covers words in the macro, in flight and in the prefetch buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (run & flush_i) begin
      count_o <= '0;
    end else begin
      count_o <= count_o + CNT_W'(push) - CNT_W'(out_fire);
    end
  end

  fifo_sram_ctrl_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (run & flush_i),
    .rd_issue (mac_rden_o),
    .rd_data  (mac_do_i),
    .pop      (out_fire),
    .buf_cnt  (buf_cnt),
    .inflight (inflight),
    .valid    (buf_valid),
    .data     (out_data_o)
  );

endmodule

// File: tb/tb_fifo_sram_ctrl.sv
// Scoreboard bench for fifo_sram_ctrl driving a behavioural FIFO macro model.
module tb_fifo_sram_ctrl;

  localparam int DW    = 32;
  localparam int DEPTH = 512;
  localparam int CNT_W = $clog2(DEPTH + 3);

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             flush_i = 1'b0;
  logic             in_valid_i = 1'b0;
  logic             in_ready_o;
  logic [DW-1:0]    in_data_i = '0;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [DW-1:0]    out_data_o;
  logic [CNT_W-1:0] count_o;
  logic             busy_o;
  logic             err_o;
  logic             mac_rst;
  logic             mac_wren;
  logic [DW-1:0]    mac_di;
  logic             mac_rden;
  logic [DW-1:0]    mac_do = '0;
  logic             mac_empty;
  logic             mac_full;
  logic             mac_rderr;
  logic             mac_wrerr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_sram_ctrl #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_data_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_data_o),
    .count_o    (count_o),
    .busy_o     (busy_o),
    .err_o      (err_o),
    .mac_rst_o  (mac_rst),
    .mac_wren_o (mac_wren),
    .mac_di_o   (mac_di),
    .mac_rden_o (mac_rden),
    .mac_do_i   (mac_do),
    .mac_empty_i(mac_empty),
    .mac_full_i (mac_full),
    .mac_rderr_i(mac_rderr),
    .mac_wrerr_i(mac_wrerr)
  );

  // Macro model: 1-cycle read latency, a written word becomes readable 3 cycles later.
  logic [DW-1:0] mem [0:DEPTH-1];
  int            wptr = 0;
  int            rptr = 0;
  int            total = 0;
  int            vis = 0;
  logic [1:0]    vis_pipe = 2'b00;
  logic          m_rderr = 1'b0;
  logic          m_wrerr = 1'b0;
  logic          inj_wrerr = 1'b0;

  assign mac_empty = (vis == 0);
  assign mac_full  = (total == DEPTH);
  assign mac_rderr = m_rderr;
  assign mac_wrerr = m_wrerr | inj_wrerr;

  always @(posedge clk) begin : macro_model
    logic w;
    logic r;
    if (mac_rst) begin
      wptr <= 0; rptr <= 0; total <= 0; vis <= 0;
      vis_pipe <= 2'b00; m_rderr <= 1'b0; m_wrerr <= 1'b0; mac_do <= '0;
    end else begin
      w = mac_wren && (total < DEPTH);
      r = mac_rden && (vis > 0);
      if (w) begin
        mem[wptr] <= mac_di;
        wptr <= (wptr + 1) % DEPTH;
      end
      if (r) begin
        mac_do <= mem[rptr];
        rptr <= (rptr + 1) % DEPTH;
      end
      total    <= total + int'(w) - int'(r);
      vis      <= vis + int'(vis_pipe[1]) - int'(r);
      vis_pipe <= {vis_pipe[0], w};
      m_rderr  <= mac_rden && (vis == 0);
      m_wrerr  <= mac_wren && (total == DEPTH);
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: samples handshakes on the falling edge, before the edge that commits them.
  logic [DW-1:0] expq[$];
  int            exp_count = 0;
  bit            mon_en = 1'b0;
  bit            stalled = 1'b0;
  logic [DW-1:0] stall_data = '0;
  int            cyc = 0;
  int            fire_cnt = 0;
  int            first_fire = -1;
  int            last_fire = -1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("count", 64'(count_o), 64'(exp_count));
      checkOutput("mac_rderr", mac_rderr, 1'b0);
      checkOutput("mac_wrerr", m_wrerr, 1'b0);
      if (mac_full) begin
        checkOutput("ready_while_full", in_ready_o, 1'b0);
        checkOutput("wren_while_full", mac_wren, 1'b0);
      end
      if (stalled && out_valid_o) checkOutput("stall_hold", out_data_o, stall_data);
      if (in_valid_i && in_ready_o) begin
        expq.push_back(in_data_i);
        exp_count++;
      end
      if (out_valid_o && out_ready_i) begin
        if (expq.size() == 0) begin
          checkOutput("spurious_out", out_valid_o, 1'b0);
        end else begin
          checkOutput("out_data", out_data_o, expq.pop_front());
        end
        exp_count--;
        fire_cnt++;
        if (first_fire < 0) first_fire = cyc;
        last_fire = cyc;
      end
      stalled    = out_valid_o && !out_ready_i;
      stall_data = out_data_o;
      if (flush_i) begin
        expq.delete();
        exp_count = 0;
        stalled   = 1'b0;
      end
    end
  end

  logic [DW-1:0] next_val = '0;

  // mode 0: consumer always ready, 1: random ready, 2: consumer stalled.
  task automatic applyStimulus(input int n, input int mode, input int max_cycles);
    int sent = 0;
    int used = 0;
    while (sent < n && used < max_cycles) begin
      in_valid_i  = 1'b1;
      in_data_i   = next_val;
      out_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (in_ready_o) begin
        sent++;
        next_val = next_val + 1;
      end
      @(posedge clk); #1;
      used++;
    end
    in_valid_i = 1'b0;
    checkOutput("push_accepted", 64'(sent), 64'(n));
  endtask

  task automatic waitDrain(input int mode, input int max_cycles);
    int used = 0;
    in_valid_i = 1'b0;
    while (used < max_cycles) begin
      out_ready_i = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      @(negedge clk);
      if (count_o == '0) break;
      @(posedge clk); #1;
      used++;
    end
    checkOutput("drain_count", 64'(count_o), 64'd0);
    checkOutput("drain_scoreboard", 64'(expq.size()), 64'd0);
    @(posedge clk); #1;
    out_ready_i = 1'b0;
  endtask

  // Walks the 10 cycles after a flush: 2 idle, 5 macro reset, 2 settle, then ready again.
  task automatic flushCheck(input bit err_before);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checkOutput("flush_count", 64'(count_o), 64'd0);
        checkOutput("flush_out_valid", out_valid_o, 1'b0);
      end
      checkOutput($sformatf("flush_mac_rst_c%0d", c), mac_rst, (c >= 3 && c <= 7));
      checkOutput($sformatf("flush_busy_c%0d", c), busy_o, (c < 10));
      checkOutput($sformatf("flush_in_ready_c%0d", c), in_ready_o, (c == 10));
      checkOutput($sformatf("flush_err_c%0d", c), err_o, err_before && (c <= 7));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mac_rst", mac_rst, 1'b1);
    checkOutput("rst_busy", busy_o, 1'b1);
    checkOutput("rst_err", err_o, 1'b0);
    checkOutput("rst_in_ready", in_ready_o, 1'b0);
    checkOutput("rst_out_valid", out_valid_o, 1'b0);
    checkOutput("rst_count", 64'(count_o), 64'd0);
    checkOutput("rst_wren", mac_wren, 1'b0);
    checkOutput("rst_rden", mac_rden, 1'b0);
    checkOutput("rst_out_data", out_data_o, '0);
    checkOutput("rst_mac_di", mac_di, '0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("seq_mac_rst_c%0d", c), mac_rst, (c < 5));
      checkOutput($sformatf("seq_busy_c%0d", c), busy_o, (c < 7));
      checkOutput($sformatf("seq_in_ready_c%0d", c), in_ready_o, (c == 7));
      @(posedge clk); #1;
    end
    mon_en = 1'b1;

    $display("[TB] streaming 16 words with consumer ready");
    fire_cnt = 0; first_fire = -1; last_fire = -1;
    applyStimulus(16, 0, 100);
    waitDrain(0, 100);
    checkOutput("stream_fires", 64'(fire_cnt), 64'd16);
    checkOutput("stream_no_gaps", 64'(last_fire - first_fire), 64'd15);

    $display("[TB] filling macro with consumer stalled");
    applyStimulus(DEPTH + 2, 2, 1200);
    in_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("full_flag", mac_full, 1'b1);
      checkOutput("full_count", 64'(count_o), 64'(DEPTH + 2));
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    waitDrain(0, 1200);

    $display("[TB] 1000-word stream with random consumer");
    applyStimulus(1000, 1, 20000);
    waitDrain(1, 20000);

    $display("[TB] flush with 3 words queued");
    applyStimulus(3, 2, 50);
    repeat (8) begin
      @(posedge clk); #1;
    end
    flush_i     = 1'b1;
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    @(negedge clk);
    checkOutput("preflush_count", 64'(count_o), 64'd3);
    checkOutput("preflush_nonempty", mac_empty, 1'b0);
    checkOutput("flush_rden_gated", mac_rden, 1'b0);
    checkOutput("flush_wren_gated", mac_wren, 1'b0);
    checkOutput("flush_ready_gated", in_ready_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0; out_ready_i = 1'b0; in_valid_i = 1'b0;
    flushCheck(1'b0);

    $display("[TB] sticky error and clear by flush");
    inj_wrerr = 1'b1;
    @(posedge clk); #1;
    inj_wrerr = 1'b0;
    @(negedge clk);
    checkOutput("err_set", err_o, 1'b1);
    repeat (4) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    checkOutput("err_held", err_o, 1'b1);
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    flushCheck(1'b1);

    applyStimulus(4, 0, 50);
    waitDrain(0, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
